// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared word size, opcode field layout and NOP/bubble encoding
package fetch_stage_pkg;

    localparam int WORD_SIZE  = 16;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_STOR = 4'h2;
    localparam logic [3:0] OP_BR   = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_NOP  = 4'hF;

    // Bubble written into IF/ID on reset; decode treats it as a no-op
    localparam logic [WORD_SIZE-1:0] NOP_INST = {OP_NOP, {(WORD_SIZE-4){1'b0}}};

endpackage

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - one-entry holding buffer in front of the IF/ID pipeline register
module if_id_buffer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         id_stall,
    input  logic         in_valid,
    input  logic [W-1:0] in_inst,
    input  logic [W-1:0] in_pc,
    input  logic [W-1:0] in_pc_next,
    output logic         accept,
    output logic         out_valid,
    output logic [W-1:0] out_inst,
    output logic [W-1:0] out_pc,
    output logic [W-1:0] out_pc_next
);
    import fetch_stage_pkg::*;

    logic         valid_q, valid_d;
    logic [W-1:0] inst_q, inst_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] pc_next_q, pc_next_d;
    logic         hold_valid_q, hold_valid_d;
    logic [W-1:0] hold_inst_q, hold_inst_d;
    logic [W-1:0] hold_pc_q, hold_pc_d;
    logic [W-1:0] hold_pc_next_q, hold_pc_next_d;

    assign accept = !valid_q || !id_stall;

    always_comb begin
        valid_d        = valid_q;
        inst_d         = inst_q;
        pc_d           = pc_q;
        pc_next_d      = pc_next_q;
        hold_valid_d   = hold_valid_q;
        hold_inst_d    = hold_inst_q;
        hold_pc_d      = hold_pc_q;
        hold_pc_next_d = hold_pc_next_q;
        if (flush) begin
            valid_d      = 1'b0;
            hold_valid_d = 1'b0;
        end else if (hold_valid_q) begin
            if (accept) begin
                valid_d      = 1'b1;
                inst_d       = hold_inst_q;
                pc_d         = hold_pc_q;
                pc_next_d    = hold_pc_next_q;
                hold_valid_d = 1'b0;
            end
        end else if (in_valid) begin
            if (accept) begin
                valid_d   = 1'b1;
                inst_d    = in_inst;
                pc_d      = in_pc;
                pc_next_d = in_pc_next;
            end else begin
                hold_valid_d   = 1'b1;
                hold_inst_d    = in_inst;
                hold_pc_d      = in_pc;
                hold_pc_next_d = in_pc_next;
            end
        end else if (accept) begin
            // Decode took the current entry and nothing replaces it
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= 1'b0;
            inst_q         <= W'(NOP_INST);
            pc_q           <= '0;
            pc_next_q      <= '0;
            hold_valid_q   <= 1'b0;
            hold_inst_q    <= '0;
            hold_pc_q      <= '0;
            hold_pc_next_q <= '0;
        end else begin
            valid_q        <= valid_d;
            inst_q         <= inst_d;
            pc_q           <= pc_d;
            pc_next_q      <= pc_next_d;
            hold_valid_q   <= hold_valid_d;
            hold_inst_q    <= hold_inst_d;
            hold_pc_q      <= hold_pc_d;
            hold_pc_next_q <= hold_pc_next_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_inst    = inst_q;
    assign out_pc      = pc_q;
    assign out_pc_next = pc_next_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, request state machine, redirect squash
module fetch_stage #(
    parameter int                    WORD_SIZE = fetch_stage_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0]  RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 i_req,
    output logic [WORD_SIZE-1:0] i_addr,
    input  logic                 i_ack,
    input  logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 id_stall,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 if_id_valid,
    output logic [WORD_SIZE-1:0] if_id_inst,
    output logic [WORD_SIZE-1:0] if_id_pc,
    output logic [WORD_SIZE-1:0] if_id_pc_next
);
    import fetch_stage_pkg::*;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] disc_addr_q, disc_addr_d;
    logic [WORD_SIZE-1:0] pc_plus1;
    logic                 accept;
    logic                 mem_valid;

    assign pc_plus1 = pc_q + WORD_SIZE'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        mem_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) pc_d = redirect_pc;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (!i_ack) begin
                        // The outstanding read must finish at its old address
                        state_d     = S_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end else if (i_ack) begin
                    mem_valid = 1'b1;
                    pc_d      = pc_plus1;
                    state_d   = accept ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (accept) begin
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (i_ack) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            disc_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    assign i_req  = (state_q == S_REQ) || (state_q == S_DISCARD);
    assign i_addr = (state_q == S_DISCARD) ? disc_addr_q : pc_q;

    if_id_buffer #(
        .W(WORD_SIZE)
    ) u_if_id_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .id_stall   (id_stall),
        .in_valid   (mem_valid),
        .in_inst    (i_rdata),
        .in_pc      (pc_q),
        .in_pc_next (pc_plus1),
        .accept     (accept),
        .out_valid  (if_id_valid),
        .out_inst   (if_id_inst),
        .out_pc     (if_id_pc),
        .out_pc_next(if_id_pc_next)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with randomized memory and decode
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req, i_ack = 1'b0;
    logic [15:0] i_addr, i_rdata = '0;
    logic        id_stall = 1'b0, redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [15:0] if_id_inst, if_id_pc, if_id_pc_next;

    logic        w_reset = 1'b1, w_ack = 1'b0, w_stall = 1'b0, w_redir = 1'b0;
    logic [15:0] w_rdata = '0, w_redir_pc = '0;
    logic        w_i_req, w_valid;
    logic [15:0] w_i_addr, w_inst, w_pc, w_pc_next;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .i_rdata(i_rdata), .id_stall(id_stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
        .if_id_pc(if_id_pc), .if_id_pc_next(if_id_pc_next)
    );

    fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .reset(w_reset), .i_req(w_i_req), .i_addr(w_i_addr), .i_ack(w_ack),
        .i_rdata(w_rdata), .id_stall(w_stall), .redirect_valid(w_redir),
        .redirect_pc(w_redir_pc), .if_id_valid(w_valid), .if_id_inst(w_inst),
        .if_id_pc(w_pc), .if_id_pc_next(w_pc_next)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a ^ 16'h5AC3) + {a[7:0], a[15:8]};
    endfunction

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Memory responder: acks a request after it has been presented for lat cycles
    bit mem_auto = 1'b0;
    bit lat_rand = 1'b0;
    int fixed_lat = 1;
    int cur_lat = 1;
    int age = 0;
    initial begin
        forever begin
            tick();
            if (mem_auto) begin
                i_ack = 1'b0;
                if (reset || !i_req) begin
                    age = 0;
                end else if (age >= (lat_rand ? cur_lat : fixed_lat)) begin
                    i_ack   = 1'b1;
                    i_rdata = mem_word(i_addr);
                    age     = 0;
                    cur_lat = $urandom_range(1, 3);
                end else begin
                    age++;
                end
            end
        end
    end

    initial begin
        forever begin
            tick();
            w_ack   = w_i_req && !w_ack && !w_reset;
            w_rdata = mem_word(w_i_addr);
        end
    end

    // Scoreboard: decode must see program order, restarting at each redirect target
    logic [15:0] redir_q[$];
    bit          mon_en = 1'b0;
    logic [15:0] exp_pc = '0;
    int          n_delivered = 0;
    logic        pv_valid, pv_stall, pv_redirect, pv_req, pv_ack;
    logic [15:0] pv_inst, pv_pc, pv_next, pv_addr;
    initial begin
        pv_valid = 0; pv_stall = 0; pv_redirect = 0; pv_req = 0; pv_ack = 0;
        pv_inst = '0; pv_pc = '0; pv_next = '0; pv_addr = '0;
        forever begin
            at_neg();
            if (!mon_en) begin
                pv_valid = 0; pv_redirect = 0; pv_req = 0;
            end else begin
                if (pv_redirect) begin
                    chk1("redirect_squash", if_id_valid, 1'b0);
                end else if (pv_valid && pv_stall) begin
                    chk1("stall_hold_valid", if_id_valid, 1'b1);
                    chk16("stall_hold_inst", if_id_inst, pv_inst);
                    chk16("stall_hold_pc", if_id_pc, pv_pc);
                    chk16("stall_hold_pc_next", if_id_pc_next, pv_next);
                end else if (if_id_valid) begin
                    chk16("deliver_pc", if_id_pc, exp_pc);
                    chk16("deliver_inst", if_id_inst, mem_word(exp_pc));
                    chk16("deliver_pc_next", if_id_pc_next, exp_pc + 16'd1);
                    exp_pc = exp_pc + 16'd1;
                    n_delivered++;
                end
                if (pv_req && !pv_ack && i_req) chk16("addr_stable", i_addr, pv_addr);
                if (redirect_valid) begin
                    chk1("redirect_queue_nonempty", redir_q.size() > 0, 1'b1);
                    if (redir_q.size() > 0) exp_pc = redir_q.pop_front();
                end
                pv_valid = if_id_valid; pv_stall = id_stall; pv_redirect = redirect_valid;
                pv_inst = if_id_inst; pv_pc = if_id_pc; pv_next = if_id_pc_next;
                pv_req = i_req; pv_ack = i_ack; pv_addr = i_addr;
            end
        end
    end

    task automatic do_reset();
        mon_en = 0;
        reset = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        redir_q.delete();
        exp_pc = 16'h0000;
        mon_en = 1;
    endtask

    task automatic wait_ack_addr(input logic [15:0] a);
        bit ok = 0;
        for (int c = 0; c < 40; c++) begin
            at_neg();
            if (i_req && i_ack && i_addr == a) begin ok = 1; break; end
        end
        chk1("wait_ack_addr_timeout", ok, 1'b1);
    endtask

    task automatic wait_delivery(input logic [15:0] pc);
        bit ok = 0;
        for (int c = 0; c < 40; c++) begin
            at_neg();
            if (if_id_valid) begin ok = 1; break; end
        end
        chk1("wait_delivery_timeout", ok, 1'b1);
        chk16("delivery_pc", if_id_pc, pc);
    endtask

    logic [15:0] ad[3], dv_pc[3], dv_inst[3], dv_next[3];
    logic [15:0] wa[2];
    initial begin
        int n_addr, n_dv;
        bit prev_ack, got;
        logic [15:0] prev_addr, fpc, fnext, finst;

        // Reset values and in-order fetch with single-cycle ack latency
        mem_auto = 1; lat_rand = 0; fixed_lat = 1;
        tick(); tick();
        at_neg();
        chk1("reset_i_req", i_req, 1'b0);
        chk1("reset_valid", if_id_valid, 1'b0);
        chk16("reset_inst", if_id_inst, NOP_INST);
        chk16("reset_pc", if_id_pc, 16'h0000);
        chk16("reset_pc_next", if_id_pc_next, 16'h0000);
        do_reset();
        n_addr = 0; n_dv = 0; prev_ack = 0; prev_addr = '0;
        for (int c = 0; c < 40 && n_dv < 3; c++) begin
            at_neg();
            if (prev_ack) begin
                chk1("ack_to_valid_latency", if_id_valid, 1'b1);
                chk16("latency_pc", if_id_pc, prev_addr);
            end
            if (if_id_valid) begin
                dv_pc[n_dv] = if_id_pc; dv_inst[n_dv] = if_id_inst; dv_next[n_dv] = if_id_pc_next;
                n_dv++;
            end
            prev_ack = i_req && i_ack; prev_addr = i_addr;
            if (i_req && i_ack && n_addr < 3) begin ad[n_addr] = i_addr; n_addr++; end
        end
        chk1("seq_count", (n_addr == 3) && (n_dv == 3), 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk16("seq_addr", ad[k], 16'(k));
            chk16("seq_pc", dv_pc[k], 16'(k));
            chk16("seq_inst", dv_inst[k], mem_word(16'(k)));
            chk16("seq_pc_next", dv_next[k], 16'(k + 1));
        end

        // Stall while the next word arrives: HOLD, then release
        do_reset();
        wait_ack_addr(16'h0004);
        tick(); id_stall = 1'b1;
        at_neg();
        chk16("stall_setup_pc", if_id_pc, 16'h0004);
        wait_ack_addr(16'h0005);
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk1("hold_i_req", i_req, 1'b0);
            chk1("hold_valid", if_id_valid, 1'b1);
            chk16("hold_pc", if_id_pc, 16'h0004);
            chk16("hold_inst", if_id_inst, mem_word(16'h0004));
        end
        tick(); id_stall = 1'b0;
        tick(); at_neg();
        chk1("release_valid", if_id_valid, 1'b1);
        chk16("release_inst", if_id_inst, mem_word(16'h0005));
        chk16("release_pc", if_id_pc, 16'h0005);
        chk16("release_pc_next", if_id_pc_next, 16'h0006);
        chk16("release_next_addr", i_addr, 16'h0006);

        // Redirect with the outstanding ack three cycles later
        do_reset();
        mem_auto = 0; i_ack = 1'b0;
        tick();
        chk1("c_req_up", i_req, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 16'h0040; redir_q.push_back(16'h0040);
        tick(); redirect_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            at_neg();
            chk1("discard_req", i_req, 1'b1);
            chk16("discard_addr", i_addr, 16'h0000);
            chk1("discard_valid", if_id_valid, 1'b0);
            tick();
        end
        i_ack = 1'b1; i_rdata = 16'hDEAD;
        at_neg();
        chk16("discard_addr_at_ack", i_addr, 16'h0000);
        tick(); i_ack = 1'b0;
        at_neg();
        chk1("after_discard_req", i_req, 1'b1);
        chk16("after_discard_addr", i_addr, 16'h0040);
        chk1("after_discard_valid", if_id_valid, 1'b0);
        mem_auto = 1;
        wait_delivery(16'h0040);

        // Redirect, ack and stall in the same cycle
        do_reset();
        mem_auto = 0; i_ack = 1'b0;
        tick();
        i_ack = 1'b1; i_rdata = mem_word(16'h0000);
        tick(); i_ack = 1'b0;
        id_stall = 1'b1; i_ack = 1'b1; i_rdata = mem_word(16'h0001);
        redirect_valid = 1'b1; redirect_pc = 16'h1234; redir_q.push_back(16'h1234);
        at_neg();
        chk1("d_pre_valid", if_id_valid, 1'b1);
        tick(); i_ack = 1'b0; redirect_valid = 1'b0;
        at_neg();
        chk1("d_valid_cleared", if_id_valid, 1'b0);
        chk1("d_req", i_req, 1'b1);
        chk16("d_addr", i_addr, 16'h1234);
        tick(); id_stall = 1'b0; mem_auto = 1;
        wait_delivery(16'h1234);

        // Reset while DISCARD has an ack outstanding; the stale ack is ignored
        do_reset();
        mem_auto = 0; i_ack = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0080; redir_q.push_back(16'h0080);
        tick(); redirect_valid = 1'b0;
        at_neg();
        chk1("e_discard_req", i_req, 1'b1);
        tick(); mon_en = 0; reset = 1'b1;
        tick(); i_ack = 1'b1; i_rdata = 16'hBEEF;
        at_neg();
        chk1("e_reset_req", i_req, 1'b0);
        chk1("e_reset_valid", if_id_valid, 1'b0);
        chk16("e_reset_inst", if_id_inst, NOP_INST);
        chk16("e_reset_pc", if_id_pc, 16'h0000);
        chk16("e_reset_pc_next", if_id_pc_next, 16'h0000);
        tick(); reset = 1'b0;
        at_neg();
        chk1("e_idle_req", i_req, 1'b0);
        chk1("e_idle_valid", if_id_valid, 1'b0);
        tick(); i_ack = 1'b0;
        at_neg();
        chk1("e_stale_valid", if_id_valid, 1'b0);
        chk1("e_req", i_req, 1'b1);
        chk16("e_addr", i_addr, 16'h0000);
        redir_q.delete(); exp_pc = 16'h0000; mon_en = 1; mem_auto = 1;
        wait_delivery(16'h0000);

        // Wrapping PC from RESET_PC=16'hFFFF
        at_neg();
        chk1("w_reset_req", w_i_req, 1'b0);
        chk1("w_reset_valid", w_valid, 1'b0);
        chk16("w_reset_pc", w_pc, 16'h0000);
        tick(); w_reset = 1'b0;
        n_addr = 0; got = 0; fpc = '0; fnext = '0; finst = '0;
        for (int c = 0; c < 30 && (n_addr < 2 || !got); c++) begin
            at_neg();
            if (w_i_req && w_ack && n_addr < 2) begin wa[n_addr] = w_i_addr; n_addr++; end
            if (w_valid && !got) begin got = 1; fpc = w_pc; fnext = w_pc_next; finst = w_inst; end
        end
        chk1("w_count", (n_addr == 2) && got, 1'b1);
        chk16("w_addr0", wa[0], 16'hFFFF);
        chk16("w_addr1", wa[1], 16'h0000);
        chk16("w_first_pc", fpc, 16'hFFFF);
        chk16("w_first_pc_next", fnext, 16'h0000);
        chk16("w_first_inst", finst, mem_word(16'hFFFF));

        // Randomized decode stalls, redirects and memory latency
        do_reset();
        lat_rand = 1; mem_auto = 1; n_delivered = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            id_stall = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 14) == 0);
            if (redirect_valid) begin
                redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
                redir_q.push_back(redirect_pc);
            end
        end
        tick(); redirect_valid = 1'b0; id_stall = 1'b0;
        tick(); tick();
        chk1("rand_deliveries", n_delivered > 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
